// File: rtl/ddr_tx_pkg.sv
// Shared types for the DDR transmit burst scheduler and its helpers.
package ddr_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_e;

   // Index width that stays legal for a single requester as well.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int NUM_REQ_DFLT = 4;
   localparam int GRANT_BITS   = clog2_min1(NUM_REQ_DFLT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational circular priority search: first set request at or after i_ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int GW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [GW-1:0] i_ptr,
   output logic [GW-1:0] o_gnt,
   output logic          o_any
);

   logic [GW-1:0] w_idx;

   // Walk from the farthest slot back toward i_ptr so the nearest request wins.
   always_comb begin
      o_gnt = '0;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = GW'((int'(i_ptr) + k) % N);
         if (i_req[w_idx]) o_gnt = w_idx;
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/ddr_tx_burst_arbiter.sv
// Round-robin burst scheduler feeding the din0/din1 registers of a DDR output bank.
module ddr_tx_burst_arbiter
   import ddr_tx_pkg::*;
#(
   parameter int               WIDTH      = 16,
   parameter int               NUM_REQ    = 4,
   parameter int               GAP_CYCLES = 2,
   parameter int               MAX_BURST  = 64,
   parameter logic [WIDTH-1:0] IDLE_WORD  = '0,
   localparam int              GW         = clog2_min1(NUM_REQ)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_d0,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_d1,
   input  logic [NUM_REQ-1:0]       i_req_last,
   output logic [WIDTH-1:0]         o_dout0,
   output logic [WIDTH-1:0]         o_dout1,
   output logic                     o_dout_en,
   output logic [GW-1:0]            o_grant_id,
   output logic                     o_busy,
   output logic                     o_err_trunc
);

   localparam int BW = $clog2(MAX_BURST + 1);

   state_e         r_state;
   logic [GW-1:0]  r_rr_ptr;
   logic [GW-1:0]  r_grant_id;
   logic [BW-1:0]  r_beat_cnt;
   logic [3:0]     r_gap_cnt;
   logic [WIDTH-1:0] r_dout0, r_dout1;
   logic           r_dout_en, r_err_trunc;

   logic [GW-1:0]  w_arb_gnt;
   logic           w_any, w_xfer, w_last, w_at_limit;
   logic [BW-1:0]  w_cnt_inc;

   rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_rr (
      .i_req (i_req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_any (w_any)
   );

   assign w_xfer     = (r_state == BURST) && i_req_valid[r_grant_id];
   assign w_last     = i_req_last[r_grant_id];
   assign w_cnt_inc  = r_beat_cnt + 1'b1;
   assign w_at_limit = (w_cnt_inc == BW'(MAX_BURST));

   // Ready is decoded from state so an async reset drops it without a clock edge.
   always_comb begin
      o_req_ready = '0;
      if (r_state == BURST) o_req_ready[r_grant_id] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_beat_cnt  <= '0;
         r_gap_cnt   <= '0;
         r_dout0     <= IDLE_WORD;
         r_dout1     <= IDLE_WORD;
         r_dout_en   <= 1'b0;
         r_err_trunc <= 1'b0;
      end else begin
         r_dout0     <= IDLE_WORD;
         r_dout1     <= IDLE_WORD;
         r_dout_en   <= 1'b0;
         r_err_trunc <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant_id <= w_arb_gnt;
                  r_beat_cnt <= '0;
                  r_state    <= BURST;
               end
            end
            BURST: begin
               if (w_xfer) begin
                  r_dout0    <= i_req_d0[r_grant_id*WIDTH +: WIDTH];
                  r_dout1    <= i_req_d1[r_grant_id*WIDTH +: WIDTH];
                  r_dout_en  <= 1'b1;
                  r_beat_cnt <= w_cnt_inc;
                  if (w_last || w_at_limit) begin
                     // A last beat landing exactly on the limit is a clean end.
                     r_err_trunc <= w_at_limit && !w_last;
                     r_rr_ptr    <= (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                     if (GAP_CYCLES == 0) begin
                        r_state <= IDLE;
                     end else begin
                        r_gap_cnt <= 4'(GAP_CYCLES);
                        r_state   <= GAP;
                     end
                  end
               end
            end
            GAP: begin
               r_gap_cnt <= r_gap_cnt - 1'b1;
               if (r_gap_cnt == 4'd1) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_dout0     = r_dout0;
   assign o_dout1     = r_dout1;
   assign o_dout_en   = r_dout_en;
   assign o_grant_id  = r_grant_id;
   assign o_busy      = (r_state != IDLE);
   assign o_err_trunc = r_err_trunc;

endmodule

// File: tb/tb_ddr_tx_burst_arbiter.sv
// Randomized scoreboard bench: a cycle-level burst/grant model predicts ready and bus output.
module tb_ddr_tx_burst_arbiter;

   localparam int W = 16, N = 4, GAP = 2, MAXB = 64;
   localparam logic [W-1:0] IDLEW = 16'h5A5A;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0, req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_d0 = '0, req_d1 = '0;
   logic [W-1:0]   dout0, dout1;
   logic           dout_en, busy, err_trunc;
   logic [1:0]     grant_id;

   always #5 clk = ~clk;

   ddr_tx_burst_arbiter #(.WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(GAP), .MAX_BURST(MAXB),
                          .IDLE_WORD(IDLEW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_d0(req_d0), .i_req_d1(req_d1), .i_req_last(req_last),
      .o_dout0(dout0), .o_dout1(dout1), .o_dout_en(dout_en), .o_grant_id(grant_id),
      .o_busy(busy), .o_err_trunc(err_trunc));

   typedef struct { logic en; logic [W-1:0] d0; logic [W-1:0] d1; logic err; } exp_t;
   exp_t q[$];

   int n_cmp = 0, n_bad = 0, err_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Requester stimulus state
   int pend_len[N];
   int bn[N];
   logic [W-1:0] cur_d0[N], cur_d1[N];
   bit dir_data = 0, arrive_en = 0, rr_refill = 0, stall_en = 0;
   int stall_cnt = 0;

   // Reference model: who owns the bus and when the next grant may appear
   bit m_active = 0;
   int m_g = 0, m_beats = 0, m_ptr = 0, m_arb_ok = 0, cyc = 0;
   logic [N-1:0] prev_valid = '0;

   function automatic int arb(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   function automatic int new_len();
      int r = $urandom_range(0, 19);
      if (r == 0) return MAXB;
      if (r == 1) return MAXB + 2;
      return $urandom_range(1, 8);
   endfunction

   task automatic new_data(input int i);
      if (dir_data) begin
         cur_d0[i] = W'(32'hA000 + bn[i]);
         cur_d1[i] = W'(32'hB000 + bn[i]);
      end else begin
         cur_d0[i] = W'($urandom);
         cur_d1[i] = W'($urandom);
      end
   endtask

   task automatic step();
      logic [N-1:0] v, exp_rdy;
      exp_t e;
      bit lastb;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (arrive_en && pend_len[i] == 0 && $urandom_range(0, 5) == 0) pend_len[i] = new_len();
         if (rr_refill && pend_len[i] == 0) pend_len[i] = 1;
      end
      if (!m_active && cyc >= m_arb_ok && prev_valid != '0) begin
         m_active = 1;
         m_g      = arb(prev_valid, m_ptr);
         m_beats  = 0;
      end
      exp_rdy = '0;
      if (m_active) exp_rdy[m_g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_active || (cyc < m_arb_ok - 1)));
      if (m_active) chk("grant_id", 32'(grant_id), 32'(m_g));

      for (int i = 0; i < N; i++) v[i] = (pend_len[i] > 0);
      if (m_active && v[m_g]) begin
         if (stall_cnt > 0) begin v[m_g] = 1'b0; stall_cnt--; end
         else if (stall_en && $urandom_range(0, 3) == 0) v[m_g] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         req_d0[i*W +: W] = cur_d0[i];
         req_d1[i*W +: W] = cur_d1[i];
         req_last[i]      = (pend_len[i] == 1);
      end
      req_valid = v;

      e = '{en: 1'b0, d0: IDLEW, d1: IDLEW, err: 1'b0};
      if (m_active && v[m_g]) begin
         lastb   = (pend_len[m_g] == 1);
         m_beats++;
         e = '{en: 1'b1, d0: cur_d0[m_g], d1: cur_d1[m_g], err: (m_beats == MAXB) && !lastb};
         pend_len[m_g]--;
         bn[m_g]++;
         new_data(m_g);
         if (lastb || m_beats == MAXB) begin
            m_active = 0;
            m_ptr    = (m_g + 1) % N;
            m_arb_ok = cyc + GAP + 2;
         end
      end
      q.push_back(e);
      prev_valid = v;
      cyc++;
   endtask

   function automatic bit all_quiet();
      bit b = !m_active;
      for (int i = 0; i < N; i++) if (pend_len[i] != 0) b = 0;
      return b;
   endfunction

   task automatic drain();
      for (int t = 0; t < 4000 && !all_quiet(); t++) step();
      chk("drain_done", 32'(all_quiet()), 32'd1);
      repeat (GAP + 3) step();
   endtask

   // Monitor: compares registered bus outputs one clock after each model step
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (err_trunc === 1'b1) err_seen++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("dout_en", 32'(dout_en), 32'(e.en));
            chk("dout0", 32'(dout0), 32'(e.d0));
            chk("dout1", 32'(dout1), 32'(e.d1));
            chk("err_trunc", 32'(err_trunc), 32'(e.err));
         end
      end
   end

   initial begin
      int e0;
      for (int i = 0; i < N; i++) begin pend_len[i] = 0; bn[i] = 1; new_data(i); end
      repeat (3) @(negedge clk);
      chk("rst_dout0", 32'(dout0), 32'(IDLEW));
      chk("rst_dout1", 32'(dout1), 32'(IDLEW));
      chk("rst_en", 32'(dout_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      rst_n = 1'b1;
      repeat (8) step();

      // Single directed burst from requester 2
      dir_data = 1; bn[2] = 1; new_data(2); pend_len[2] = 3;
      drain();
      dir_data = 0; new_data(2);

      // All requesters contend with one-beat bursts
      rr_refill = 1;
      repeat (40) step();
      rr_refill = 0;
      drain();

      // Forced 4-clock stall mid-burst
      pend_len[1] = 6;
      for (int t = 0; t < 200 && !(m_active && m_g == 1 && m_beats == 2); t++) step();
      chk("stall_reach", 32'(m_active && m_g == 1 && m_beats == 2), 32'd1);
      stall_cnt = 4;
      drain();

      // Randomized traffic with stalls
      arrive_en = 1; stall_en = 1;
      repeat (900) step();
      arrive_en = 0; stall_en = 0;
      drain();

      // Truncation: 70 beats without an early last
      e0 = err_seen;
      pend_len[0] = 70;
      for (int t = 0; t < 50 && !(m_active && m_g == 0); t++) step();
      pend_len[1] = 2;
      drain();
      chk("trunc_pulses", 32'(err_seen - e0), 32'd1);

      // Async reset in the middle of a burst
      pend_len[3] = 10;
      for (int t = 0; t < 200 && !(m_active && m_g == 3 && m_beats == 5); t++) step();
      chk("rst_reach", 32'(m_beats), 32'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_en", 32'(dout_en), 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_dout0", 32'(dout0), 32'(IDLEW));
      q.delete();
      req_valid = '0;
      for (int i = 0; i < N; i++) pend_len[i] = 0;
      m_active = 0; m_ptr = 0; m_arb_ok = 0; prev_valid = '0; cyc = 0; stall_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step();
      chk("post_rst_gid", 32'(grant_id), 32'd0);
      pend_len[2] = 2;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ddr_tx_burst_arbiter.md
Name: ddr_tx_burst_arbiter

Overview:
- Shares one ganged DDR output bus (WIDTH pins, two bits per pin per clock) between NUM_REQ burst-oriented requesters.
- Arbitration is round-robin. Each grant covers one whole burst, and a fixed guard gap follows every burst.
- Drives the din0/din1 inputs of the DDR output buffer bank from registers in the clk domain. When no burst is active it drives a programmable idle pattern.

Parameters:
- WIDTH, 16, pin count of the DDR bus (bits per half-word).
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 2, idle clocks inserted after each burst (0..15).
- MAX_BURST, 64, beat limit per grant; the burst is force-terminated when the limit is reached.
- IDLE_WORD, 0, value driven on both dout0 and dout1 when no data is being sent.

Ports:
- clk  in  1  bus clock; the same clk_p that feeds the DDR output buffer bank.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero.
- req_d0  in  NUM_REQ*WIDTH  rising-edge half-word; requester i occupies slice [i*WIDTH +: WIDTH].
- req_d1  in  NUM_REQ*WIDTH  falling-edge half-word, same slicing.
- req_last  in  NUM_REQ  final beat of the burst; qualified by valid&ready.
- dout0  out  WIDTH  to the DDR buffer din0.
- dout1  out  WIDTH  to the DDR buffer din1.
- dout_en  out  1  high when dout0/dout1 carry a data beat; drives the tristate and strobe logic.
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grantee.
- busy  out  1  high in BURST or GAP.
- err_trunc  out  1  one-cycle pulse when a burst is cut off at MAX_BURST.

Behaviour:
- Reset values (asynchronous, all registers):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, gap_cnt=0.
  - dout0=dout1=IDLE_WORD, dout_en=0, req_ready=0, busy=0, err_trunc=0.
- States are IDLE, BURST and GAP.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, grant the first requester i with req_valid[i]=1, searching circularly from rr_ptr.
  - Latch grant_id=i, clear beat_cnt, move to BURST on the next clock.
  - With no valid requester, stay in IDLE.
- BURST:
  - req_ready[grant_id]=1 (combinational from state and grant_id); all other ready bits are 0.
  - A beat is transferred on a clock where req_valid[g] and req_ready[g] are both high.
  - On a transfer, the next clock registers dout0=req_d0 slice, dout1=req_d1 slice, dout_en=1, and beat_cnt increments. Latency from accepted beat to the DDR buffer inputs is exactly 1 clk.
  - If req_valid[g] is low (stall), the next clock gives dout=IDLE_WORD, dout_en=0, and the state stays in BURST. There is no stall timeout.
  - Exit on a transfer with req_last=1, or on a transfer that brings beat_cnt to MAX_BURST. A truncated exit pulses err_trunc on the next clock.
  - On exit: rr_ptr=(g+1) mod NUM_REQ.
    - If GAP_CYCLES=0, go to IDLE. Re-arbitration then takes one IDLE clock, so bursts are separated by at least 1 idle clock.
    - Otherwise load gap_cnt=GAP_CYCLES and go to GAP.
- GAP:
  - req_ready=0, dout=IDLE_WORD, dout_en=0.
  - gap_cnt decrements each clock; go to IDLE when it reaches 1.
  - Total bus idle between bursts is GAP_CYCLES+1 clocks, counting the IDLE arbitration clock.
- Requesters dropping req_valid after a grant is legal; the bus simply idles in BURST until the grantee sends again.
- When the last beat and the MAX_BURST limit coincide on the same transfer, it counts as a normal end: no err_trunc.
- If rst_n asserts mid-burst, all outputs return to their reset values immediately. Any beat in flight is lost and no partial state persists.
- busy = (state != IDLE).

Decomposition:
- Shared package ddr_tx_pkg holds:
  - the state enum typedef (IDLE, BURST, GAP);
  - the localparam GRANT_BITS = clog2(NUM_REQ) helper.
- One sub-module, rr_arbiter: a combinational circular priority search.
  - Inputs: request vector and rr_ptr. Outputs: grant index and any-request flag.
  - Reusable by other bus schedulers in the codebase.
- The FSM, counters and output registers stay in ddr_tx_burst_arbiter.

Test Plan:
- Reset and idle: hold rst_n=0, then release with all valids low. Required: dout0=dout1=IDLE_WORD, dout_en=0 and busy=0 indefinitely.
- Single burst: requester 2 sends 3 beats with d0=16'hA000+n, d1=16'hB000+n, last on beat 3. Required:
  - req_ready[2] rises 1 clk after valid;
  - dout_en is high for exactly 3 consecutive clks, 1 clk after each accept, with matching data;
  - then 2 GAP clks plus 1 IDLE clk;
  - rr_ptr=3.
- Round robin: all 4 requesters hold valid and send 1-beat bursts (last=1). Required: grant_id sequence 0,1,2,3,0 and no requester granted twice before all others are served.
- Stall: the grantee drops valid for 4 clks mid-burst. Required: dout_en=0 and dout=IDLE_WORD for those 4 clks, state stays BURST, other requesters see ready=0.
- Truncation: with MAX_BURST=64, requester 0 streams 70 beats without last. Required: exactly 64 beats accepted, err_trunc pulses once, requester 1 is granted next.
- Async reset mid-burst: assert rst_n=0 between clock edges on beat 5. Required: dout_en=0 and req_ready=0 within the same cycle (no clock edge), state=IDLE after release.
